// File: rtl/m_mc_core.sv
// Multi-cycle RV32I subset core: FETCH/DECODE/EXEC/WB sequencing with a req/ack
// instruction port, a private register file and a sticky illegal-encoding flag.
module m_mc_core #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          IADDR_W  = 6,
   parameter int          NREGS    = 32,
   parameter int          HALT_REG = 30
) (
   input  logic               w_clk,
   input  logic               w_rst,
   output logic               w_imem_req,
   output logic [IADDR_W-1:0] w_imem_addr,
   input  logic               w_imem_ack,
   input  logic [31:0]        w_imem_data,
   output logic [31:0]        w_pc,
   output logic               w_retire,
   output logic               w_wb_en,
   output logic [4:0]         w_wb_addr,
   output logic [31:0]        w_wb_data,
   output logic               w_halted,
   output logic               w_illegal
);

   localparam int RA_W = $clog2(NREGS);

   localparam logic [6:0] OP_IMM = 7'b0010011;
   localparam logic [6:0] OP_REG = 7'b0110011;
   localparam logic [6:0] OP_LUI = 7'b0110111;
   localparam logic [6:0] OP_BR  = 7'b1100011;
   localparam logic [6:0] OP_JAL = 7'b1101111;

   typedef enum logic [2:0] {FETCH, DECODE, EXEC, WB, HALT} state_t;

   state_t      state;
   logic [31:0] ir;
   logic [31:0] rs1_val;
   logic [31:0] rs2_val;
   logic [31:0] imm;
   logic [31:0] next_pc;
   logic [31:0] regs [NREGS];

   logic [6:0]  opcode;
   logic [2:0]  f3;
   logic [6:0]  f7;
   logic [4:0]  rd;
   logic [4:0]  rs1;
   logic [4:0]  rs2;
   logic [31:0] rs1_rd;
   logic [31:0] rs2_rd;
   logic [31:0] imm_dec;
   logic [31:0] alu_res;
   logic        do_write;
   logic        legal;
   logic        taken;
   logic        wr_ok;

   assign opcode = ir[6:0];
   assign rd     = ir[11:7];
   assign f3     = ir[14:12];
   assign rs1    = ir[19:15];
   assign rs2    = ir[24:20];
   assign f7     = ir[31:25];

   assign w_imem_addr = w_pc[IADDR_W+1:2];

   // Index 0 and indices beyond the implemented file both read as zero.
   assign rs1_rd = (rs1 != 5'd0 && int'(rs1) < NREGS) ? regs[rs1[RA_W-1:0]] : 32'h0;
   assign rs2_rd = (rs2 != 5'd0 && int'(rs2) < NREGS) ? regs[rs2[RA_W-1:0]] : 32'h0;

   always_comb begin
      case (opcode)
         OP_LUI:  imm_dec = {ir[31:12], 12'b0};
         OP_BR:   imm_dec = {{20{ir[31]}}, ir[7], ir[30:25], ir[11:8], 1'b0};
         OP_JAL:  imm_dec = {{12{ir[31]}}, ir[19:12], ir[20], ir[30:21], 1'b0};
         default: imm_dec = {{20{ir[31]}}, ir[31:20]};
      endcase
   end

   // Unrecognised encodings fall out with legal=0, no write and no redirect.
   always_comb begin
      alu_res  = 32'h0;
      do_write = 1'b0;
      legal    = 1'b1;
      taken    = 1'b0;
      case (opcode)
         OP_IMM: begin
            if (f3 == 3'b000) begin
               alu_res  = rs1_val + imm;
               do_write = 1'b1;
            end else begin
               legal = 1'b0;
            end
         end
         OP_REG: begin
            do_write = 1'b1;
            case ({f7, f3})
               10'b0000000_000: alu_res = rs1_val + rs2_val;
               10'b0100000_000: alu_res = rs1_val - rs2_val;
               10'b0000000_100: alu_res = rs1_val ^ rs2_val;
               10'b0000000_110: alu_res = rs1_val | rs2_val;
               10'b0000000_111: alu_res = rs1_val & rs2_val;
               default: begin
                  do_write = 1'b0;
                  legal    = 1'b0;
               end
            endcase
         end
         OP_LUI: begin
            alu_res  = imm;
            do_write = 1'b1;
         end
         OP_BR: begin
            if (f3 == 3'b000)      taken = (rs1_val == rs2_val);
            else if (f3 == 3'b001) taken = (rs1_val != rs2_val);
            else                   legal = 1'b0;
         end
         OP_JAL: begin
            alu_res  = w_pc + 32'd4;
            do_write = 1'b1;
            taken    = 1'b1;
         end
         default: legal = 1'b0;
      endcase
   end

   assign wr_ok = do_write && (rd != 5'd0) && (int'(rd) < NREGS);

   always_ff @(posedge w_clk or posedge w_rst) begin
      if (w_rst) begin
         state      <= FETCH;
         w_pc       <= RESET_PC;
         ir         <= 32'h0;
         rs1_val    <= 32'h0;
         rs2_val    <= 32'h0;
         imm        <= 32'h0;
         next_pc    <= 32'h0;
         w_imem_req <= 1'b0;
         w_retire   <= 1'b0;
         w_wb_en    <= 1'b0;
         w_wb_addr  <= 5'd0;
         w_wb_data  <= 32'h0;
         w_halted   <= 1'b0;
         w_illegal  <= 1'b0;
         for (int i = 0; i < NREGS; i++) regs[i] <= 32'h0;
      end else begin
         case (state)
            // req is registered, so the first cycle after reset only raises it.
            FETCH: begin
               if (!w_imem_req) begin
                  w_imem_req <= 1'b1;
               end else if (w_imem_ack) begin
                  ir         <= w_imem_data;
                  w_imem_req <= 1'b0;
                  state      <= DECODE;
               end
            end
            DECODE: begin
               rs1_val <= rs1_rd;
               rs2_val <= rs2_rd;
               imm     <= imm_dec;
               state   <= EXEC;
            end
            EXEC: begin
               w_retire  <= 1'b1;
               w_wb_en   <= wr_ok;
               w_wb_addr <= rd;
               w_wb_data <= alu_res;
               next_pc   <= taken ? (w_pc + imm) : (w_pc + 32'd4);
               if (!legal) w_illegal <= 1'b1;
               state     <= WB;
            end
            WB: begin
               w_retire <= 1'b0;
               w_wb_en  <= 1'b0;
               if (w_wb_en) regs[w_wb_addr[RA_W-1:0]] <= w_wb_data;
               w_pc     <= next_pc;
               if (w_wb_en && int'(w_wb_addr) == HALT_REG) begin
                  w_halted <= 1'b1;
                  state    <= HALT;
               end else begin
                  w_imem_req <= 1'b1;
                  state      <= FETCH;
               end
            end
            HALT: state <= HALT;
            default: state <= FETCH;
         endcase
      end
   end

endmodule

// File: tb/tb_m_mc_core.sv
// Scoreboard bench for m_mc_core: a 32-register core on a delay-programmable memory
// model and a 16-register build on a same-cycle-ack memory.
module tb_m_mc_core;

   typedef struct packed {
      logic [31:0] pc;
      logic        en;
      logic [4:0]  rd;
      logic [31:0] data;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req, ack = 1'b0;
   logic [5:0]  addr;
   logic [31:0] data = 32'h0;
   logic [31:0] pc, wb_data;
   logic        retire, wb_en, halted, illegal;
   logic [4:0]  wb_addr;

   logic        rst16 = 1'b1;
   logic        req16, ack16;
   logic [5:0]  addr16;
   logic [31:0] data16, pc16, wb_data16;
   logic        retire16, wb_en16, halted16, illegal16;
   logic [4:0]  wb_addr16;

   logic [31:0] mem   [64];
   logic [31:0] mem16 [64];
   int          delay = 0;
   int          wcnt  = 0;
   int          cyc   = 0;
   int          nret  = 0;
   int          ret_cyc [64];
   int          total = 0;
   int          passed = 0;
   exp_t        exp_q[$];
   exp_t        exp16_q[$];

   m_mc_core dut (
      .w_clk(clk), .w_rst(rst), .w_imem_req(req), .w_imem_addr(addr),
      .w_imem_ack(ack), .w_imem_data(data), .w_pc(pc), .w_retire(retire),
      .w_wb_en(wb_en), .w_wb_addr(wb_addr), .w_wb_data(wb_data),
      .w_halted(halted), .w_illegal(illegal)
   );

   m_mc_core #(.NREGS(16), .HALT_REG(15)) dut16 (
      .w_clk(clk), .w_rst(rst16), .w_imem_req(req16), .w_imem_addr(addr16),
      .w_imem_ack(ack16), .w_imem_data(data16), .w_pc(pc16), .w_retire(retire16),
      .w_wb_en(wb_en16), .w_wb_addr(wb_addr16), .w_wb_data(wb_data16),
      .w_halted(halted16), .w_illegal(illegal16)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   assign ack16  = req16;
   assign data16 = mem16[addr16];

   // Memory model: ack after 'delay' waiting cycles of a held request.
   always @(negedge clk) begin
      if (req) begin
         if (wcnt == delay) begin
            ack  = 1'b1;
            data = mem[addr];
         end else begin
            ack = 1'b0;
            wcnt++;
         end
      end else begin
         ack  = 1'b0;
         wcnt = 0;
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
      else passed++;
   endtask

   task automatic applyStimulus(input logic [31:0] epc, input logic en, input logic [4:0] rd,
                                input logic [31:0] val);
      exp_t e;
      e.pc = epc; e.en = en; e.rd = rd; e.data = val;
      exp_q.push_back(e);
   endtask

   // Monitor: every retirement is compared against the next queued expectation.
   always @(negedge clk) begin
      if (!rst && retire) begin
         exp_t e;
         if (nret < 64) ret_cyc[nret] = cyc;
         nret++;
         checkOutput("retire_expected", 32'(exp_q.size() != 0), 32'd1);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            checkOutput("retire_pc", pc, e.pc);
            checkOutput("wb_en", 32'(wb_en), 32'(e.en));
            if (e.en) begin
               checkOutput("wb_addr", 32'(wb_addr), 32'(e.rd));
               checkOutput("wb_data", wb_data, e.data);
            end
         end
      end
   end

   always @(negedge clk) begin
      if (!rst16 && retire16) begin
         exp_t e;
         checkOutput("r16_retire_expected", 32'(exp16_q.size() != 0), 32'd1);
         if (exp16_q.size() != 0) begin
            e = exp16_q.pop_front();
            checkOutput("r16_retire_pc", pc16, e.pc);
            checkOutput("r16_wb_en", 32'(wb_en16), 32'(e.en));
            if (e.en) begin
               checkOutput("r16_wb_addr", 32'(wb_addr16), 32'(e.rd));
               checkOutput("r16_wb_data", wb_data16, e.data);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      logic found;
      logic req_seen;
      exp_t e;

      for (int i = 0; i < 64; i++) begin
         mem[i]   = 32'h0000_0000;
         mem16[i] = 32'h0000_006F;
      end
      mem[0]  = 32'h0050_0093;  // ADDI x1,x0,5
      mem[1]  = 32'hFFD0_0113;  // ADDI x2,x0,-3
      mem[2]  = 32'h0020_81B3;  // ADD  x3,x1,x2
      mem[3]  = 32'h4020_8233;  // SUB  x4,x1,x2
      mem[4]  = 32'h0020_F2B3;  // AND  x5,x1,x2
      mem[5]  = 32'h0020_E333;  // OR   x6,x1,x2
      mem[6]  = 32'h0020_C3B3;  // XOR  x7,x1,x2
      mem[7]  = 32'h1234_5437;  // LUI  x8,0x12345
      mem[8]  = 32'h0000_9463;  // 0x20 BNE x1,x0,+8
      mem[9]  = 32'h0630_0F93;  // 0x24 ADDI x31,x0,99 (skipped)
      mem[10] = 32'h0005_9863;  // 0x28 BNE x11,x0,+16
      mem[11] = 32'h0010_0593;  // 0x2C ADDI x11,x0,1
      mem[12] = 32'hFF9F_F2EF;  // 0x30 JAL x5,-8
      mem[14] = 32'h0000_8463;  // 0x38 BEQ x1,x0,+8
      mem[15] = 32'h0070_0013;  // 0x3C ADDI x0,x0,7
      mem[16] = 32'h0000_04B3;  // 0x40 ADD x9,x0,x0
      mem[17] = 32'h0000_0000;  // 0x44 illegal
      mem[18] = 32'h0002_8633;  // 0x48 ADD x12,x5,x0
      mem[19] = 32'h0010_0F13;  // 0x4C ADDI x30,x0,1
      mem16[0] = 32'h0010_0A13; // ADDI x20,x0,1
      mem16[1] = 32'h000A_00B3; // ADD  x1,x20,x0
      mem16[2] = 32'h0070_8793; // ADDI x15,x1,7

      repeat (2) @(negedge clk);
      #1;
      checkOutput("rst_req", 32'(req), 32'd0);
      checkOutput("rst_pc", pc, 32'h0);
      checkOutput("rst_addr", 32'(addr), 32'd0);
      checkOutput("rst_retire", 32'(retire), 32'd0);
      checkOutput("rst_wb_en", 32'(wb_en), 32'd0);
      checkOutput("rst_halted", 32'(halted), 32'd0);
      checkOutput("rst_illegal", 32'(illegal), 32'd0);

      applyStimulus(32'h00, 1'b1, 5'd1,  32'h0000_0005);
      applyStimulus(32'h04, 1'b1, 5'd2,  32'hFFFF_FFFD);
      applyStimulus(32'h08, 1'b1, 5'd3,  32'h0000_0002);
      applyStimulus(32'h0C, 1'b1, 5'd4,  32'h0000_0008);
      applyStimulus(32'h10, 1'b1, 5'd5,  32'h0000_0005);
      applyStimulus(32'h14, 1'b1, 5'd6,  32'hFFFF_FFFD);
      applyStimulus(32'h18, 1'b1, 5'd7,  32'hFFFF_FFF8);
      applyStimulus(32'h1C, 1'b1, 5'd8,  32'h1234_5000);
      applyStimulus(32'h20, 1'b0, 5'd0,  32'h0);
      applyStimulus(32'h28, 1'b0, 5'd0,  32'h0);
      applyStimulus(32'h2C, 1'b1, 5'd11, 32'h0000_0001);
      applyStimulus(32'h30, 1'b1, 5'd5,  32'h0000_0034);
      applyStimulus(32'h28, 1'b0, 5'd0,  32'h0);
      applyStimulus(32'h38, 1'b0, 5'd0,  32'h0);
      applyStimulus(32'h3C, 1'b0, 5'd0,  32'h0);
      applyStimulus(32'h40, 1'b1, 5'd9,  32'h0000_0000);
      applyStimulus(32'h44, 1'b0, 5'd0,  32'h0);
      applyStimulus(32'h48, 1'b1, 5'd12, 32'h0000_0034);
      applyStimulus(32'h4C, 1'b1, 5'd30, 32'h0000_0001);

      @(negedge clk);
      nret = 0;
      rst  = 1'b0;

      found = 1'b0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         #1;
         if (retire && wb_en && wb_addr == 5'd30) begin
            found = 1'b1;
            break;
         end
      end
      checkOutput("halt_write_seen", 32'(found), 32'd1);
      checkOutput("halted_before", 32'(halted), 32'd0);
      @(negedge clk);
      #1;
      checkOutput("halted_next", 32'(halted), 32'd1);
      checkOutput("illegal_held", 32'(illegal), 32'd1);
      checkOutput("interval_0", 32'(ret_cyc[1] - ret_cyc[0]), 32'd4);
      checkOutput("interval_1", 32'(ret_cyc[2] - ret_cyc[1]), 32'd4);

      req_seen = 1'b0;
      repeat (20) begin
         @(negedge clk);
         #1;
         req_seen = req_seen | req;
      end
      checkOutput("halt_req_quiet", 32'(req_seen), 32'd0);
      checkOutput("halt_retire_count", 32'(nret), 32'd19);
      checkOutput("queue_drained", 32'(exp_q.size()), 32'd0);

      rst = 1'b1;
      #1;
      checkOutput("rst_clears_halted", 32'(halted), 32'd0);
      checkOutput("rst_clears_illegal", 32'(illegal), 32'd0);
      checkOutput("rst_pc_after_halt", pc, 32'h0);

      // Three wait cycles on every fetch.
      @(negedge clk);
      delay = 3;
      nret  = 0;
      applyStimulus(32'h00, 1'b1, 5'd1, 32'h0000_0005);
      applyStimulus(32'h04, 1'b1, 5'd2, 32'hFFFF_FFFD);
      rst = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         #1;
         if (nret >= 2) break;
      end
      checkOutput("slow_two_retired", 32'(nret), 32'd2);
      checkOutput("slow_interval", 32'(ret_cyc[1] - ret_cyc[0]), 32'd7);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         #1;
         checkOutput("pending_req", 32'(req), 32'd1);
         checkOutput("pending_addr", 32'(addr), 32'd2);
         checkOutput("pending_no_retire", 32'(retire), 32'd0);
      end
      #2;
      rst = 1'b1;
      #1;
      checkOutput("midfetch_req_drop", 32'(req), 32'd0);
      checkOutput("midfetch_pc", pc, 32'h0);
      repeat (3) @(negedge clk);
      #1;
      checkOutput("midfetch_retires", 32'(nret), 32'd2);
      checkOutput("midfetch_queue", 32'(exp_q.size()), 32'd0);

      // 16-register build: writes and reads above x15 are discarded / zero.
      e.pc = 32'h0; e.en = 1'b0; e.rd = 5'd0;  e.data = 32'h0; exp16_q.push_back(e);
      e.pc = 32'h4; e.en = 1'b1; e.rd = 5'd1;  e.data = 32'h0; exp16_q.push_back(e);
      e.pc = 32'h8; e.en = 1'b1; e.rd = 5'd15; e.data = 32'h7; exp16_q.push_back(e);
      @(negedge clk);
      rst16 = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         #1;
         if (halted16) break;
      end
      checkOutput("r16_halted", 32'(halted16), 32'd1);
      checkOutput("r16_queue", 32'(exp16_q.size()), 32'd0);
      checkOutput("r16_illegal", 32'(illegal16), 32'd0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
